// File: rtl/poly_basemul_sequencer.sv
// Sequences one polynomial basemul pass: walks coefficient pairs, fetches A/B/R/zeta,
// drives the basemul engine and writes (optionally accumulated) results back into R.
`timescale 1ns/1ps
module poly_basemul_sequencer #(
   parameter int COEFF_W   = 16,
   parameter int KYBER_N   = 256,
   parameter int ZETA_BASE = 64
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               accumulate,
   output logic               busy,
   output logic               done,
   output logic [7:0]         a_addr,
   output logic [7:0]         b_addr,
   output logic [7:0]         r_raddr,
   input  logic [COEFF_W-1:0] a_rdata,
   input  logic [COEFF_W-1:0] b_rdata,
   input  logic [COEFF_W-1:0] r_rdata,
   output logic [6:0]         z_addr,
   input  logic [COEFF_W-1:0] z_rdata,
   output logic               bm_enable,
   output logic [COEFF_W-1:0] bm_a0,
   output logic [COEFF_W-1:0] bm_b0,
   output logic [COEFF_W-1:0] bm_a1,
   output logic [COEFF_W-1:0] bm_b1,
   output logic [COEFF_W-1:0] bm_zeta,
   input  logic               bm_done,
   input  logic [COEFF_W-1:0] bm_r0,
   input  logic [COEFF_W-1:0] bm_r1,
   output logic               wr_en,
   output logic [7:0]         wr_addr,
   output logic [COEFF_W-1:0] wr_data
);
   localparam int PW = $clog2(KYBER_N/2);
   localparam logic [PW-1:0] LAST_P = PW'(KYBER_N/2 - 1);

   typedef enum logic [2:0] {IDLE, RD0, RD1, CAP, ISSUE, WAIT, WR0, WR1} state_t;

   state_t             r_state;
   logic [PW-1:0]      r_p;
   logic               r_acc, r_busy, r_done, r_bm_en, r_wr_en;
   logic [7:0]         r_addr, r_wr_addr;
   logic [6:0]         r_zaddr;
   logic [COEFF_W-1:0] r_a0, r_b0, r_a1, r_b1, r_zeta;
   logic [COEFF_W-1:0] r_old0, r_old1, r_res1, r_wr_data;

   logic [PW-1:0]      w_p_nxt;
   logic [7:0]         w_even, w_even_nxt;
   logic [6:0]         w_zaddr_nxt;
   logic [COEFF_W-1:0] w_add0, w_add1;

   assign w_p_nxt     = r_p + PW'(1);
   assign w_even      = 8'({r_p, 1'b0});
   assign w_even_nxt  = 8'({w_p_nxt, 1'b0});
   assign w_zaddr_nxt = 7'(ZETA_BASE) + 7'(w_p_nxt >> 1);
   assign w_add0      = r_acc ? r_old0 : '0;
   assign w_add1      = r_acc ? r_old1 : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_p       <= '0;
         r_acc     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_bm_en   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_addr    <= '0;
         r_wr_addr <= '0;
         r_zaddr   <= '0;
         r_a0      <= '0;
         r_b0      <= '0;
         r_a1      <= '0;
         r_b1      <= '0;
         r_zeta    <= '0;
         r_old0    <= '0;
         r_old1    <= '0;
         r_res1    <= '0;
         r_wr_data <= '0;
      end else begin
         r_done  <= 1'b0;
         r_bm_en <= 1'b0;
         r_wr_en <= 1'b0;
         case (r_state)
            IDLE: if (start) begin
               r_state <= RD0;
               r_p     <= '0;
               r_acc   <= accumulate;
               r_busy  <= 1'b1;
               r_addr  <= '0;
               r_zaddr <= 7'(ZETA_BASE);
            end
            RD0: begin
               r_state <= RD1;
               r_addr  <= w_even | 8'd1;
            end
            RD1: begin
               // odd pairs use the negated zeta of the shared ROM entry
               r_a0    <= a_rdata;
               r_b0    <= b_rdata;
               r_old0  <= r_rdata;
               r_zeta  <= r_p[0] ? ('0 - z_rdata) : z_rdata;
               r_state <= CAP;
            end
            CAP: begin
               r_a1    <= a_rdata;
               r_b1    <= b_rdata;
               r_old1  <= r_rdata;
               r_bm_en <= 1'b1;
               r_state <= ISSUE;
            end
            ISSUE: r_state <= WAIT;
            WAIT: if (bm_done) begin
               r_wr_en   <= 1'b1;
               r_wr_addr <= w_even;
               r_wr_data <= bm_r0 + w_add0;
               r_res1    <= bm_r1 + w_add1;
               r_state   <= WR0;
            end
            WR0: begin
               r_wr_en   <= 1'b1;
               r_wr_addr <= w_even | 8'd1;
               r_wr_data <= r_res1;
               r_state   <= WR1;
            end
            WR1: begin
               if (r_p == LAST_P) begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_p     <= w_p_nxt;
                  r_addr  <= w_even_nxt;
                  r_zaddr <= w_zaddr_nxt;
                  r_state <= RD0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign a_addr    = r_addr;
   assign b_addr    = r_addr;
   assign r_raddr   = r_addr;
   assign z_addr    = r_zaddr;
   assign bm_enable = r_bm_en;
   assign bm_a0     = r_a0;
   assign bm_b0     = r_b0;
   assign bm_a1     = r_a1;
   assign bm_b1     = r_b1;
   assign bm_zeta   = r_zeta;
   assign wr_en     = r_wr_en;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
endmodule

// File: tb/tb_poly_basemul_sequencer.sv
// Directed bench for poly_basemul_sequencer with A/B/R/zeta memory models and a basemul engine model.
`timescale 1ns/1ps
module tb_poly_basemul_sequencer;
   localparam int W = 16;

   logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, accumulate = 1'b0;
   logic busy, done, bm_enable, wr_en, bm_done;
   logic [7:0] a_addr, b_addr, r_raddr, wr_addr;
   logic [6:0] z_addr;
   logic [W-1:0] a_rdata = '0, b_rdata = '0, r_rdata = '0, z_rdata = '0;
   logic [W-1:0] bm_a0, bm_b0, bm_a1, bm_b1, bm_zeta, bm_r0, bm_r1, wr_data;

   always #5 clk = ~clk;

   poly_basemul_sequencer #(.COEFF_W(W), .KYBER_N(256), .ZETA_BASE(64)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .accumulate(accumulate),
      .busy(busy), .done(done),
      .a_addr(a_addr), .b_addr(b_addr), .r_raddr(r_raddr),
      .a_rdata(a_rdata), .b_rdata(b_rdata), .r_rdata(r_rdata),
      .z_addr(z_addr), .z_rdata(z_rdata),
      .bm_enable(bm_enable), .bm_a0(bm_a0), .bm_b0(bm_b0), .bm_a1(bm_a1), .bm_b1(bm_b1),
      .bm_zeta(bm_zeta), .bm_done(bm_done), .bm_r0(bm_r0), .bm_r1(bm_r1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   logic [W-1:0] A [256], B [256], R [256], RE [256], ZR [128];
   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // memories with 1-cycle read latency; bench-side write port for preloading R
   logic tb_we = 1'b0;
   logic [7:0] tb_wa = '0;
   logic [W-1:0] tb_wd = '0;
   always @(posedge clk) begin
      a_rdata <= A[a_addr];
      b_rdata <= B[b_addr];
      r_rdata <= R[r_raddr];
      z_rdata <= ZR[z_addr];
      if (wr_en) R[wr_addr] <= wr_data;
      else if (tb_we) R[tb_wa] <= tb_wd;
   end

   // engine: fixed-latency response in auto mode, or manual pulses from the stimulus
   logic eng_auto = 1'b1, eng_done = 1'b0, man_done = 1'b0;
   int eng_cnt = 0;
   logic [W-1:0] eng_r0 = '0, eng_r1 = '0, man_r0 = '0, man_r1 = '0;
   always @(posedge clk) begin
      eng_done <= 1'b0;
      if (eng_cnt > 0) begin
         eng_cnt <= eng_cnt - 1;
         if (eng_cnt == 1) eng_done <= 1'b1;
      end
      if (bm_enable && eng_auto) begin
         eng_r0  <= 16'(bm_a0 * bm_b0 + bm_a1 * bm_b1 * bm_zeta);
         eng_r1  <= 16'(bm_a0 * bm_b1 + bm_a1 * bm_b0);
         eng_cnt <= 3;
      end
   end
   assign bm_done = eng_done | man_done;
   assign bm_r0   = man_done ? man_r0 : eng_r0;
   assign bm_r1   = man_done ? man_r1 : eng_r1;

   // pass monitor: counts pulses and checks write ordering
   int wr_cnt = 0, en_cnt = 0, done_cnt = 0, order_err = 0;
   logic [7:0] exp_wa = '0, last_wa = '0;
   logic [W-1:0] zseen [128];
   logic [6:0] zaseen [128];
   always @(posedge clk) begin
      if (bm_enable) begin
         if (en_cnt < 128) begin
            zseen[en_cnt]  <= bm_zeta;
            zaseen[en_cnt] <= z_addr;
         end
         en_cnt <= en_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (wr_en) wr_cnt <= wr_cnt + 1;
      if (!busy) exp_wa <= '0;
      else if (wr_en) begin
         if (wr_addr != exp_wa) order_err <= order_err + 1;
         exp_wa  <= wr_addr + 8'd1;
         last_wa <= wr_addr;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 5000) begin @(negedge clk); n++; end
      chk({tag, " done"}, 32'(done), 32'd1);
   endtask

   task automatic wait_en(input int target, input string tag);
      int n = 0;
      while (en_cnt < target && n < 2000) begin @(negedge clk); n++; end
      chk({tag, " enable reached"}, 32'(en_cnt >= target), 32'd1);
   endtask

   int serve_to = 0;
   task automatic serve(input logic [W-1:0] r0, input logic [W-1:0] r1);
      int n = 0;
      while (!bm_enable && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) serve_to++;
      tick(1);
      man_r0 = r0; man_r1 = r1; man_done = 1'b1;
      tick(1);
      man_done = 1'b0;
   endtask

   initial begin
      int err, viol, base_en, base_wr;
      logic [W-1:0] z, e0, e1;
      for (int i = 0; i < 256; i++) begin
         A[i] = 16'($urandom);
         B[i] = 16'($urandom);
      end
      for (int i = 0; i < 128; i++) ZR[i] = 16'($urandom);
      ZR[64] = 16'h0011;
      ZR[65] = 16'h1234;

      // reset
      #1 reset_n = 1'b0;
      tick(2);
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst wr_en", 32'(wr_en), 0);
      chk("rst bm_enable", 32'(bm_enable), 0);
      chk("rst a_addr", 32'(a_addr), 0);
      chk("rst z_addr", 32'(z_addr), 0);
      chk("rst wr_data", 32'(wr_data), 0);
      reset_n = 1'b1;
      tick(2);

      // full pass, engine latency 3, stray start during WAIT of pair 5
      accumulate = 1'b0; start = 1'b1; tick(1); start = 1'b0;
      chk("p1 busy", 32'(busy), 1);
      wait_en(6, "p1 pair5");
      start = 1'b1; tick(1); start = 1'b0;
      wait_done("p1");
      chk("p1 busy@done", 32'(busy), 0);
      chk("p1 last waddr", 32'(last_wa), 255);
      chk("p1 writes", 32'(wr_cnt), 256);
      chk("p1 enables", 32'(en_cnt), 128);
      chk("p1 order", 32'(order_err), 0);
      tick(1);
      chk("p1 done pulse", 32'(done), 0);
      chk("p1 done count", 32'(done_cnt), 1);
      chk("p1 no restart", 32'(busy), 0);
      chk("zeta p0", 32'(zseen[0]), 32'h0011);
      chk("zeta p1", 32'(zseen[1]), 32'hFFEF);
      chk("zeta p2", 32'(zseen[2]), 32'h1234);
      chk("zaddr p0", 32'(zaseen[0]), 64);
      chk("zaddr p1", 32'(zaseen[1]), 64);
      chk("zaddr p2", 32'(zaseen[2]), 65);
      chk("zaddr p127", 32'(zaseen[127]), 127);
      err = 0;
      for (int p = 0; p < 128; p++) begin
         z = ZR[64 + (p >> 1)];
         if (p % 2 == 1) z = 16'h0 - z;
         e0 = A[2*p] * B[2*p] + A[2*p+1] * B[2*p+1] * z;
         e1 = A[2*p] * B[2*p+1] + A[2*p+1] * B[2*p];
         if (R[2*p] !== e0 || R[2*p+1] !== e1) err++;
      end
      chk("p1 R model", 32'(err), 0);

      // accumulate pass with a manual engine, stray bm_done in IDLE and RD1, 50-cycle holdoff
      eng_auto = 1'b0;
      tb_wa = 8'd0; tb_wd = 16'h7FFF; tb_we = 1'b1; tick(1); tb_we = 1'b0;
      for (int i = 0; i < 256; i++) RE[i] = R[i];
      man_done = 1'b1; tick(1); man_done = 1'b0; tick(1);
      chk("idle stray busy", 32'(busy), 0);
      chk("idle stray writes", 32'(wr_cnt), 256);
      accumulate = 1'b1; start = 1'b1; tick(1); start = 1'b0; accumulate = 1'b0;
      tick(1);
      man_done = 1'b1; tick(1); man_done = 1'b0;
      chk("rd1 stray wr_en", 32'(wr_en), 0);
      chk("rd1 stray busy", 32'(busy), 1);
      viol = 0;
      while (!bm_enable && viol < 20) begin tick(1); viol++; end
      chk("p2 first enable", 32'(bm_enable), 1);
      viol = 0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (bm_enable || wr_en || !busy) viol++;
      end
      chk("holdoff idle", 32'(viol), 0);
      man_r0 = 16'h0001; man_r1 = 16'h0002; man_done = 1'b1; tick(1); man_done = 1'b0;
      chk("acc wr0 en", 32'(wr_en), 1);
      chk("acc wr0 addr", 32'(wr_addr), 0);
      chk("acc wr0 data", 32'(wr_data), 32'h8000);
      tick(1);
      chk("acc wr1 addr", 32'(wr_addr), 1);
      chk("acc wr1 data", 32'(wr_data), 32'(16'(RE[1] + 16'h0002)));
      for (int p = 1; p < 128; p++) serve(16'(p * 3), 16'(p ^ 16'h5A5A));
      wait_done("p2");
      chk("p2 serve timeouts", 32'(serve_to), 0);
      chk("p2 writes", 32'(wr_cnt), 512);
      chk("p2 enables", 32'(en_cnt), 256);
      chk("p2 order", 32'(order_err), 0);
      tick(1);
      chk("acc R0 wrap", 32'(R[0]), 32'h8000);
      err = 0;
      for (int p = 1; p < 128; p++) begin
         e0 = RE[2*p] + 16'(p * 3);
         e1 = RE[2*p+1] + 16'(p ^ 16'h5A5A);
         if (R[2*p] !== e0 || R[2*p+1] !== e1) err++;
      end
      chk("p2 acc model", 32'(err), 0);

      // reset during WAIT of pair 10; pending engine response lands after release
      eng_auto = 1'b1;
      start = 1'b1; tick(1); start = 1'b0;
      base_en = en_cnt;
      wait_en(base_en + 11, "p3 pair10");
      #1 reset_n = 1'b0;
      #1;
      chk("abort busy", 32'(busy), 0);
      chk("abort wr_en", 32'(wr_en), 0);
      chk("abort bm_enable", 32'(bm_enable), 0);
      chk("abort a_addr", 32'(a_addr), 0);
      chk("abort wr_addr", 32'(wr_addr), 0);
      chk("abort wr_data", 32'(wr_data), 0);
      chk("abort bm_a0", 32'(bm_a0), 0);
      chk("abort z_addr", 32'(z_addr), 0);
      base_wr = wr_cnt;
      tick(2);
      reset_n = 1'b1;
      tick(10);
      chk("post-abort writes", 32'(wr_cnt), 32'(base_wr));
      chk("post-abort enables", 32'(en_cnt), 32'(base_en + 11));
      chk("post-abort busy", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
